// File: rtl/sensor_pkg.sv
// Shared definitions for the colour-sensor path: frequency-meter FSM
// states and the default gate window length.
package sensor_pkg;

    // Frequency-meter control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } fm_state_t;

    // Default gate window length in system-clock cycles
    localparam int unsigned FM_DEFAULT_GATE_CYCLES = 1000;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous sensor pin, followed by a third
// flop so a single-cycle rising-edge pulse can be formed in the clk domain.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic in_p0;
    logic in_p1;
    logic in_p2;

    // Synchroniser chain (in_p0/in_p1) plus the history flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_p0 <= 1'b0;
            in_p1 <= 1'b0;
            in_p2 <= 1'b0;
        end else begin
            in_p0 <= async_in;
            in_p1 <= in_p0;
            in_p2 <= in_p1;
        end
    end

    assign rise = in_p1 & ~in_p2;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronised rising edges of freq_in over
// a window of GATE_CYCLES system-clock cycles and publishes a saturating
// count plus an overflow flag at the end of each window.
module freq_meter
    import sensor_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = FM_DEFAULT_GATE_CYCLES,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             continuous,
    input  logic             freq_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int unsigned       GATE_W     = $clog2(GATE_CYCLES + 1);
    localparam logic [GATE_W-1:0] TIMER_LOAD = GATE_W'(GATE_CYCLES - 1);

    // Saturating increment: returns {attempted_past_max, new_value}.
    // At all-ones the value holds and the attempt is reported.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] val,
                                               input logic             en);
        logic [CNT_W:0] res;
        if (!en) begin
            res = {1'b0, val};
        end else if (val == {CNT_W{1'b1}}) begin
            res = {1'b1, val};
        end else begin
            res = {1'b0, val + 1'b1};
        end
        return res;
    endfunction

    fm_state_t         state;
    fm_state_t         state_nxt;
    logic [GATE_W-1:0] timer;
    logic [CNT_W-1:0]  edge_cnt;
    logic              edge_ovf;
    logic              rise;
    logic [CNT_W-1:0]  cnt_inc;
    logic              ovf_inc;
    logic              in_gate;
    logic              load_window;
    logic              window_end;

    sync_edge_det u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (freq_in),
        .rise     (rise)
    );

    assign in_gate     = (state == GATE);
    assign window_end  = in_gate && (timer == '0);
    // A new window opens from IDLE on start, or straight after DONE in continuous mode
    assign load_window = ((state == IDLE) && start) || ((state == DONE) && continuous);

    // Edge counting only happens inside the window; the last window cycle's
    // edge is folded into the published result via this same increment.
    assign {ovf_inc, cnt_inc} = sat_inc(edge_cnt, rise & in_gate);

    // Next-state decode for the window FSM
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)      state_nxt = GATE;
            GATE:    if (timer == '0) state_nxt = DONE;
            DONE:    state_nxt = continuous ? GATE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Gate timer: loaded when a window opens, counts down to zero inside it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (load_window) begin
            timer <= TIMER_LOAD;
        end else if (in_gate && (timer != '0)) begin
            timer <= timer - 1'b1;
        end
    end

    // Working edge counter and sticky overflow for the open window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt <= '0;
            edge_ovf <= 1'b0;
        end else if (load_window) begin
            edge_cnt <= '0;
            edge_ovf <= 1'b0;
        end else if (in_gate) begin
            edge_cnt <= cnt_inc;
            edge_ovf <= edge_ovf | ovf_inc;
        end
    end

    // Published result, captured as the window closes so it is valid during DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (window_end) begin
            count    <= cnt_inc;
            overflow <= edge_ovf | ovf_inc;
        end
    end

    assign busy = in_gate;
    assign done = (state == DONE);

endmodule

// File: tb/tb_freq_meter.sv
`timescale 1ns/100ps
module tb_freq_meter;

    localparam int G = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start2;
    logic        continuous;
    logic        cont2;
    logic        freq_in = 1'b0;
    logic        busy, done, overflow;
    logic [15:0] count;
    logic        busy2, done2, overflow2;
    logic [3:0]  count2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rises[$];
    int half_hi  = 5;
    int half_lo  = 5;
    bit gen_en   = 1'b0;
    int pulses   = 0;
    int pulses2  = 0;

    freq_meter #(.GATE_CYCLES(G), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous),
        .freq_in(freq_in), .busy(busy), .done(done), .count(count),
        .overflow(overflow)
    );

    freq_meter #(.GATE_CYCLES(G), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .start(start2), .continuous(cont2),
        .freq_in(freq_in), .busy(busy2), .done(done2), .count(count2),
        .overflow(overflow2)
    );

    initial forever #0.5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (done)  pulses++;
        if (done2) pulses2++;
    end

    // Square-wave source; each rise is logged with the index of the clk
    // edge that first samples it.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            if (!gen_en) begin
                freq_in = 1'b0;
                ph = 0;
            end else begin
                ph++;
                if (ph >= (freq_in ? half_hi : half_lo)) begin
                    ph = 0;
                    freq_in = ~freq_in;
                    if (freq_in) rises.push_back(cyc + 1);
                end
            end
        end
    end

    // Rises first sampled at clk edge a reach the edge detector two edges
    // later; a window opened at edge k therefore owns a in [k-1, k+G-2].
    function automatic int exp_edges(input int k);
        int n;
        n = 0;
        foreach (rises[i])
            if (rises[i] >= k - 1 && rises[i] <= k + G - 2) n++;
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic pulse_start(output int k);
        start = 1'b1;
        k = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_start2(output int k);
        start2 = 1'b1;
        k = cyc + 1;
        @(negedge clk);
        start2 = 1'b0;
    endtask

    task automatic check_window(input string tag, input int k, input bit sat);
        int n;
        wait_to(k + G - 1);
        check({tag, "_busy_last"}, sat ? busy2 : busy, 1);
        check({tag, "_done_early"}, sat ? done2 : done, 0);
        wait_to(k + G);
        n = exp_edges(k);
        if (!sat) begin
            check({tag, "_done"}, done, 1);
            check({tag, "_busy_done"}, busy, 0);
            check({tag, "_count"}, count, (n > 65535) ? 65535 : n);
            check({tag, "_ovf"}, overflow, (n > 65535) ? 1 : 0);
        end else begin
            check({tag, "_done"}, done2, 1);
            check({tag, "_busy_done"}, busy2, 0);
            check({tag, "_count"}, count2, (n > 15) ? 15 : n);
            check({tag, "_ovf"}, overflow2, (n > 15) ? 1 : 0);
        end
    endtask

    initial begin
        int k;
        int p0;
        rst        = 1'b1;
        start      = 1'b0;
        start2     = 1'b0;
        continuous = 1'b0;
        cont2      = 1'b0;

        tick(3);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_count_sat", count2, 0);
        rst = 1'b0;

        // Nominal: 10-cycle period, 100 edges per window
        gen_en  = 1'b1;
        half_hi = 5;
        half_lo = 5;
        tick($urandom_range(5, 25));
        p0 = pulses;
        pulse_start(k);
        check("nom_busy_first", busy, 1);
        check_window("nom", k, 0);
        check("nom_count_abs", count, 100);
        tick(10);
        check("nom_one_pulse", pulses - p0, 1);
        check("nom_hold_count", count, 100);

        // Reset in the middle of a window
        tick(5);
        pulse_start(k);
        p0 = pulses;
        wait_to(k + 500);
        rst = 1'b1;
        #0.1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_count", count, 0);
        check("midrst_ovf", overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_to(k + G + 5);
        check("midrst_no_pulse", pulses - p0, 0);
        tick(20);
        pulse_start(k);
        check_window("post_rst", k, 0);

        // Random periods within the guaranteed-counting range
        for (int r = 0; r < 2; r++) begin
            half_hi = $urandom_range(2, 9);
            half_lo = $urandom_range(2, 9);
            tick($urandom_range(5, 30));
            pulse_start(k);
            check_window("rand", k, 0);
        end

        // Saturation on the 4-bit instance: 8-cycle period, 125 edges
        half_hi = 4;
        half_lo = 4;
        tick($urandom_range(5, 20));
        pulse_start2(k);
        check_window("sat", k, 1);
        check("sat_count_abs", count2, 15);
        check("sat_ovf_abs", overflow2, 1);

        // Near the 4-bit limit with random slow periods
        half_hi = $urandom_range(30, 40);
        half_lo = $urandom_range(30, 40);
        tick($urandom_range(5, 20));
        pulse_start2(k);
        check_window("sat_edge", k, 1);

        // Continuous mode with a period change partway through
        half_hi = 5;
        half_lo = 5;
        tick(10);
        continuous = 1'b1;
        pulse_start(k);
        for (int i = 0; i < 4; i++) begin
            int ki;
            ki = k + i * (G + 1);
            wait_to(ki);
            check("cont_busy_open", busy, 1);
            if (i == 1) begin
                wait_to(ki + 500);
                half_hi = 10;
                half_lo = 10;
            end
            check_window("cont", ki, 0);
            if (i == 0) check("cont_first_abs", count, 100);
            if (i >= 2) check("cont_slow_abs", count, 50);
            if (i == 3) continuous = 1'b0;
        end
        tick(5);
        check("cont_stop_busy", busy, 0);

        // Start pulses while busy must be ignored
        half_hi = 5;
        half_lo = 5;
        tick(10);
        pulse_start(k);
        p0 = pulses;
        while (cyc < k + G - 20) begin
            tick($urandom_range(1, 15));
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        check_window("ign", k, 0);
        wait_to(k + G + 20);
        check("ign_one_pulse", pulses - p0, 1);
        check("ign_idle", busy, 0);

        // Idle input: no edges at all
        gen_en = 1'b0;
        tick(10);
        pulse_start(k);
        check_window("zero", k, 0);
        check("zero_count_abs", count, 0);
        check("zero_ovf_abs", overflow, 0);

        tick(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
